// File: rtl/spram_pkg.sv
// ---------------------------------------------------------------------------
// spram_pkg
//
// Shared definitions for the single-port RAM slice:
//   - SPRAM_WIDTH : default data word width (bits)
//   - SPRAM_AW    : default address width (depth = 2**SPRAM_AW words)
//   - spram_state_e : clear-sequencer state (CLEAR sweep, then RUN)
// ---------------------------------------------------------------------------
package spram_pkg;

    localparam int SPRAM_WIDTH = 8;
    localparam int SPRAM_AW    = 6;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } spram_state_e;

endpackage : spram_pkg

// File: rtl/spram_clear_seq.sv
// ---------------------------------------------------------------------------
// spram_clear_seq
//
// After reset, sweeps every address once, requesting a write of zero to each
// word, then settles in RUN for good. The sweep takes exactly DEPTH cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (restarts the sweep)
//   clear_we   out  1 = write zero to clear_addr this cycle
//   clear_addr out  word currently being cleared
//   ready      out  1 = sweep finished, RAM open for normal accesses
// ---------------------------------------------------------------------------
module spram_clear_seq
    import spram_pkg::*;
#(
    parameter int AW = SPRAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr,
    output logic          ready
);

    localparam int DEPTH = 2 ** AW;

    spram_state_e  state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The pointer wraps back to zero naturally after the last word, so it is
    // already in its reset position once RUN is reached.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clear_we   = 1'b0;
        clear_addr = ptr_q;
        ready      = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                ptr_d    = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

endmodule : spram_clear_seq

// File: rtl/single_port_ram.sv
// ---------------------------------------------------------------------------
// single_port_ram
//
// Synchronous single-port RAM, DEPTH = 2**AW words of WIDTH bits, with a
// registered write-first read port. Contents are zeroed by a sweep after every
// reset; accesses are ignored until ready rises.
//
// Optional build macro: SPRAM_PARITY_EN
//   Adds an even-parity bit per word and the parity_err output.
//
// Ports:
//   data       in   write data
//   addr       in   shared read/write address
//   clk        in   clock, rising edge
//   we         in   1 = write data to addr this cycle
//   q          out  registered read data (one cycle latency)
//   rst        in   asynchronous active-high reset
//   ready      out  1 = clear sweep done
//   parity_err out  (SPRAM_PARITY_EN only) stored word failed its parity check
// ---------------------------------------------------------------------------
module single_port_ram
    import spram_pkg::*;
#(
    parameter int WIDTH = SPRAM_WIDTH,
    parameter int AW    = SPRAM_AW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    addr,
    input  logic             clk,
    input  logic             we,
    output logic [WIDTH-1:0] q,
    input  logic             rst,
    output logic             ready
`ifdef SPRAM_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int DEPTH = 2 ** AW;
`ifdef SPRAM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0]    mem_q [DEPTH];
    logic             clear_we;
    logic [AW-1:0]    clear_addr;
    logic             mem_we_d;
    logic [AW-1:0]    mem_addr_d;
    logic [SW-1:0]    mem_wdata_d;
    logic [SW-1:0]    rd_word;
    logic [WIDTH-1:0] q_q, q_d;

    spram_clear_seq #(
        .AW(AW)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_we  (clear_we),
        .clear_addr(clear_addr),
        .ready     (ready)
    );

    assign rd_word = mem_q[addr];

    // Single write port shared between the clear sweep and user writes; the
    // sweep owns it completely until ready, so user requests are dropped.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = addr;
        mem_wdata_d = '0;
        if (clear_we) begin
            mem_we_d   = 1'b1;
            mem_addr_d = clear_addr;
        end else if (ready && we) begin
            mem_we_d = 1'b1;
`ifdef SPRAM_PARITY_EN
            mem_wdata_d = {^data, data};
`else
            mem_wdata_d = data;
`endif
        end
    end

    // Array has no reset of its own; the clear sweep provides that.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_wdata_d;
        end
    end

    // Write-first: on a write the output takes the incoming data rather than
    // the old contents.
    always_comb begin
        q_d = '0;
        if (ready) begin
            q_d = we ? data : rd_word[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifdef SPRAM_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Freshly written data cannot be corrupt, so write-first reads never flag.
    always_comb begin
        parity_err_d = 1'b0;
        if (ready && !we) begin
            parity_err_d = ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// ---------------------------------------------------------------------------
// tb_single_port_ram
//
// Self-checking bench for single_port_ram. Keeps a plain array image of the
// RAM plus a countdown of remaining clear cycles, and compares q/ready (and
// parity_err when SPRAM_PARITY_EN is defined) after every clock edge.
// ---------------------------------------------------------------------------
module tb_single_port_ram;

    localparam int WIDTH = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic [WIDTH-1:0] data;
    logic [AW-1:0]    addr;
    logic             clk;
    logic             we;
    logic [WIDTH-1:0] q;
    logic             rst;
    logic             ready;
`ifdef SPRAM_PARITY_EN
    logic             parity_err;
`endif

    int checkCount;
    int errorCount;

    // Reference image of the RAM contents and the reset/clear bookkeeping.
    logic [WIDTH-1:0] refMem [DEPTH];
    bit               refBad [DEPTH];
    bit               modelReady;
    int               clearLeft;

    single_port_ram dut (
        .data (data),
        .addr (addr),
        .clk  (clk),
        .we   (we),
        .q    (q),
        .rst  (rst),
        .ready(ready)
`ifdef SPRAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model and checks the outputs
    // just after the edge. Called shortly after a rising edge.
    task automatic applyStimulus(input bit w, input logic [AW-1:0] a,
                                 input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] expQ;
        bit               expPerr;
        we   = w;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        expQ    = '0;
        expPerr = 1'b0;
        if (modelReady) begin
            expQ    = w ? d : refMem[a];
            expPerr = !w && refBad[a];
            if (w) begin
                refMem[a] = d;
                refBad[a] = 1'b0;
            end
        end else begin
            clearLeft--;
            if (clearLeft == 0) modelReady = 1'b1;
        end
        checkOutput("q", 32'(q), 32'(expQ));
        checkOutput("ready", 32'(ready), 32'(modelReady));
`ifdef SPRAM_PARITY_EN
        checkOutput("parity_err", 32'(parity_err), 32'(expPerr));
`else
        if (expPerr) checkOutput("parity_model", 32'(0), 32'(1));
`endif
    endtask

    // Asserts reset between edges, checks the asynchronous effect at once,
    // then releases it before the following edge.
    task automatic pulseReset();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_q", 32'(q), 32'(0));
        checkOutput("rst_ready", 32'(ready), 32'(0));
        for (int i = 0; i < DEPTH; i++) begin
            refMem[i] = '0;
            refBad[i] = 1'b0;
        end
        modelReady = 1'b0;
        clearLeft  = DEPTH;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                          WIDTH'($urandom));
        end
    endtask

    task automatic readAll();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, AW'(i), WIDTH'($urandom));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst  = 1'b0;
        we   = 1'b0;
        addr = '0;
        data = '0;
        #1;

        // Reset then clear sweep with junk inputs that must be ignored.
        pulseReset();
        randomCycles(DEPTH);
        readAll();

        // Sequential writes then reads.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, AW'(i), WIDTH'(i + 1));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, AW'(i), 8'h00);

        // Read during write, then plain read back.
        applyStimulus(1'b1, 6'd7, 8'hA5);
        applyStimulus(1'b0, 6'd7, 8'h00);

        // Overwrite at the top address, then the bottom address.
        applyStimulus(1'b1, 6'd63, 8'h3C);
        applyStimulus(1'b1, 6'd63, 8'hC3);
        applyStimulus(1'b0, 6'd63, 8'h00);
        applyStimulus(1'b1, 6'd0, 8'hFF);
        applyStimulus(1'b0, 6'd63, 8'h00);
        applyStimulus(1'b0, 6'd0, 8'h00);

        // Random traffic.
        randomCycles(400);
        readAll();

        // Reset in the middle of a write burst (q is nonzero beforehand).
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(10 + i), WIDTH'(8'h50 + i));
        pulseReset();
        randomCycles(20);
        // Reset in the middle of the clear sweep.
        pulseReset();
        randomCycles(DEPTH);
        readAll();

`ifdef SPRAM_PARITY_EN
        // Corrupt one stored bit behind the RAM's back.
        applyStimulus(1'b1, 6'd3, 8'h07);
        applyStimulus(1'b1, 6'd4, 8'h12);
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        refMem[3] = refMem[3] ^ 8'h01;
        refBad[3] = 1'b1;
        applyStimulus(1'b0, 6'd3, 8'h00);
        applyStimulus(1'b0, 6'd4, 8'h00);
        applyStimulus(1'b1, 6'd3, 8'h07);
        applyStimulus(1'b0, 6'd3, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_single_port_ram

// File: doc/single_port_ram.md
Name: single_port_ram

Overview:
- Synchronous single-port RAM: DEPTH words of WIDTH bits, one shared address for read and write.
- Generic scratch/buffer storage, used directly behind small controllers.
- Write-first read-during-write semantics with a registered output.
- A reset-triggered clear sequencer zeroes the whole array so contents are deterministic after reset.

Parameters:
- WIDTH, 8, data word width in bits.
- AW, 6, address width; DEPTH = 2**AW = 64 words.

Ports:
- clk  in  1  single clock; all state changes on the rising edge except reset.
- rst  in  1  reset, asynchronous and active-high.
- data  in  WIDTH  write data.
- addr  in  AW  read/write address.
- we  in  1  write enable; 1 = write `data` to `addr` this cycle.
- q  out  WIDTH  registered read data.
- ready  out  1  1 = clear sequence done, RAM accepts accesses.

Port declaration order is data, addr, clk, we, q, rst, ready, so that existing positional instantiations of the first five ports remain valid.

Behaviour:
- Reset (rst=1, asynchronous): q=0, ready=0, clear pointer=0, state=CLEAR. This takes effect immediately regardless of clk.
- Reset asserted mid-operation (including mid-CLEAR) aborts the current state and restarts CLEAR from word 0 after deassertion.
- FSM states:
  - CLEAR: each rising edge writes 0 to mem[ptr], then ptr++. After the write of word DEPTH-1 the FSM goes to RUN and ready=1 from the next cycle. CLEAR lasts exactly DEPTH cycles after reset release.
  - RUN: normal operation; the FSM stays in RUN until reset.
- In CLEAR, we/data/addr are ignored and q holds 0.
- Write (RUN, we=1): at the rising edge, mem[addr] <= data.
- Read (RUN): at every rising edge, q <= mem[addr] (one-cycle latency). q holds its value between edges.
- Read-during-write (we=1): q <= data, i.e. the newly written value (write-first).
- Consecutive writes to the same address: the last write wins. A read the next cycle returns the last written value.
- addr covers the full 0..DEPTH-1 range. There is no out-of-range case and no wrap logic.
- Array has no per-word reset other than the CLEAR sweep.

Optional Feature:
- Macro: SPRAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed on write, or 0 during CLEAR.
  - On every RUN read the parity is recomputed and a new output `parity_err` (1 bit, declared after ready) is registered with the same latency as q. It is 1 when stored parity mismatches the stored data.
  - For a write-first read, parity_err is 0.
  - Reset value of parity_err is 0.
- When not defined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package spram_pkg: default WIDTH/AW constants, and the state enum (CLEAR, RUN).
- Sub-module spram_clear_seq: pointer counter + FSM, producing clear_we, clear_addr and ready.
- Storage array and output register stay in the top.

Test Plan:
- Reset then idle: assert rst, release -> ready=0 for 64 cycles, then ready=1. Reading addr 0..63 returns 0x00 each, one cycle after addr is applied.
- Sequential write/read: write 0x01..0x05 to addr 0..4 (we=1), then we=0 with addr 0,1,2 -> q=0x01,0x02,0x03 one cycle after each addr.
- Read-during-write: we=1, addr=7, data=0xA5 -> q=0xA5 at that same edge. Then we=0, addr=7 -> q=0xA5.
- Overwrite and boundary: write 0x3C then 0xC3 to addr 63 -> read returns 0xC3. Write 0xFF to addr 0 -> addr 63 still 0xC3.
- Reset mid-CLEAR and mid-RUN: pulse rst asynchronously between edges at cycle 20 of CLEAR and during a RUN write burst -> q=0 and ready=0 immediately. Full 64-cycle clear then reruns and all words read 0x00.
- SPRAM_PARITY_EN: write 0x07 to addr 3, force a single stored bit flip via hierarchical access, read addr 3 -> parity_err=1 with q=corrupted word. Unmodified words read with parity_err=0.
